// File: rtl/operand_dispatch.sv
// Register-read / dispatch stage: architectural register file, busy scoreboard
// with RAW/WAW stall, write-back forwarding and a DEPTH-entry in-order output queue.
module operand_dispatch #(
    parameter int  XLEN      = 32,
    parameter int  NREGS     = 32,
    parameter int  NUM_WB    = 2,
    parameter int  DEPTH     = 2,
    parameter int  PAYLOAD_W = 64,
    localparam int AW        = $clog2(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AW-1:0]          in_rs1_i,
    input  logic [AW-1:0]          in_rs2_i,
    input  logic                   in_rs1_use_i,
    input  logic                   in_rs2_use_i,
    input  logic [AW-1:0]          in_rd_i,
    input  logic                   in_rd_we_i,
    input  logic [PAYLOAD_W-1:0]   in_payload_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        out_rs1_data_o,
    output logic [XLEN-1:0]        out_rs2_data_o,
    output logic [AW-1:0]          out_rd_o,
    output logic                   out_rd_we_o,
    output logic [PAYLOAD_W-1:0]   out_payload_o,
    input  logic [NUM_WB-1:0]      wb_valid_i,
    input  logic [NUM_WB*AW-1:0]   wb_addr_i,
    input  logic [NUM_WB*XLEN-1:0] wb_data_i,
    input  logic                   flush_i,
    output logic                   hazard_stall_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [AW-1:0]        rd;
        logic                 rd_we;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NREGS-1:0] wb_hit;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic             rs1_ok, rs2_ok, waw, hazard, space, push, pop, wb_collision;
    entry_t           push_entry, head;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wb_hit  = '0;
        rs1_val = rf_q[in_rs1_i];
        rs2_val = rf_q[in_rs2_i];
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid_i[i] && wb_addr_i[i*AW +: AW] != '0) begin
                wb_hit[wb_addr_i[i*AW +: AW]] = 1'b1;
                if (wb_addr_i[i*AW +: AW] == in_rs1_i) rs1_val = wb_data_i[i*XLEN +: XLEN];
                if (wb_addr_i[i*AW +: AW] == in_rs2_i) rs2_val = wb_data_i[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        wb_collision = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            for (int j = i + 1; j < NUM_WB; j++) begin
                if (wb_valid_i[i] && wb_valid_i[j] && wb_addr_i[i*AW +: AW] != '0 &&
                    wb_addr_i[i*AW +: AW] == wb_addr_i[j*AW +: AW]) begin
                    wb_collision = 1'b1;
                end
            end
        end
    end

    assign rs1_ok = !in_rs1_use_i || in_rs1_i == '0 || !busy_q[in_rs1_i] || wb_hit[in_rs1_i];
    assign rs2_ok = !in_rs2_use_i || in_rs2_i == '0 || !busy_q[in_rs2_i] || wb_hit[in_rs2_i];
    assign waw    = in_rd_we_i && in_rd_i != '0 && busy_q[in_rd_i] && !wb_hit[in_rd_i];
    assign hazard = !rs1_ok || !rs2_ok || waw;
    assign space  = (cnt_q < CW'(DEPTH)) || out_ready_i;

    assign in_ready_o     = !rst_i && !flush_i && !hazard && space;
    assign hazard_stall_o = in_valid_i && hazard && !flush_i;
    assign out_valid_o    = cnt_q != '0;
    assign push           = in_valid_i && in_ready_o;
    assign pop            = out_valid_o && out_ready_i;

    always_comb begin
        push_entry          = '0;
        push_entry.rs1_data = (in_rs1_use_i && in_rs1_i != '0) ? rs1_val : '0;
        push_entry.rs2_data = (in_rs2_use_i && in_rs2_i != '0) ? rs2_val : '0;
        push_entry.rd       = in_rd_i;
        push_entry.rd_we    = in_rd_we_i;
        push_entry.payload  = in_payload_i;
    end

    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (flush_i) begin
            busy_d = '0;
        end else if (push && in_rd_we_i && in_rd_i != '0) begin
            busy_d[in_rd_i] = 1'b1;  // the new producer owns the register over a same-cycle clear
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
            if (pop)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
        end else begin
            busy_q <= busy_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_valid_i[i] && wb_addr_i[i*AW +: AW] != '0) begin
                    rf_q[wb_addr_i[i*AW +: AW]] <= wb_data_i[i*XLEN +: XLEN];
                end
            end
        end
    end

    // NOTE: queue storage has no reset; outputs are masked by out_valid so stale entries never leak.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_entry;
    end

    assign head           = out_valid_o ? mem_q[rptr_q] : '0;
    assign out_rs1_data_o = head.rs1_data;
    assign out_rs2_data_o = head.rs2_data;
    assign out_rd_o       = head.rd;
    assign out_rd_we_o    = head.rd_we;
    assign out_payload_o  = head.payload;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!wb_collision)
                else $warning("operand_dispatch: write-back address collision, highest port kept");
        end
    end
endmodule

// File: tb/tb_operand_dispatch.sv
// Self-checking bench for operand_dispatch: directed scenarios plus randomized
// traffic against a scoreboard model of register file, busy set and output queue.
module tb_operand_dispatch;
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [63:0] payload;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_rs1_use = 1'b0, in_rs2_use = 1'b0, in_rd_we = 1'b0;
    logic [63:0] in_payload = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [63:0] out_payload;
    logic [1:0]  wb_valid = '0;
    logic [9:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic        flush = 1'b0, hazard_stall;
    entry_t      got;

    int n_tests = 0;
    int n_fail  = 0;

    operand_dispatch dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_rs1_use_i(in_rs1_use), .in_rs2_use_i(in_rs2_use),
        .in_rd_i(in_rd), .in_rd_we_i(in_rd_we), .in_payload_i(in_payload),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_rs1_data_o(out_rs1_data), .out_rs2_data_o(out_rs2_data),
        .out_rd_o(out_rd), .out_rd_we_o(out_rd_we), .out_payload_o(out_payload),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .flush_i(flush), .hazard_stall_o(hazard_stall)
    );

    always #5 clk = ~clk;
    assign got = {out_rs1_data, out_rs2_data, out_rd, out_rd_we, out_payload};

    // Reference model: architectural state after each edge.
    logic [31:0] m_rf [32];
    bit          m_busy [32];
    entry_t      m_q [$];
    bit          e_hazard, e_in_ready, e_hstall, e_out_valid;
    entry_t      e_head;

    // Write-backs this cycle count as having already landed when judging readiness.
    function automatic void model_comb();
        bit bz [32];
        bz = m_busy;
        for (int i = 0; i < 2; i++)
            if (wb_valid[i] && wb_addr[i*5 +: 5] != 0) bz[wb_addr[i*5 +: 5]] = 1'b0;
        e_hazard = (in_rs1_use && in_rs1 != 0 && bz[in_rs1]) ||
                   (in_rs2_use && in_rs2 != 0 && bz[in_rs2]) ||
                   (in_rd_we && in_rd != 0 && bz[in_rd]);
        e_in_ready  = !rst && !flush && !e_hazard && (m_q.size() < 2 || out_ready);
        e_hstall    = in_valid && e_hazard && !flush;
        e_out_valid = m_q.size() != 0;
        e_head      = (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    task automatic tick();
        bit acc, pop;
        entry_t e;
        model_comb();
        acc = in_valid && e_in_ready;
        pop = e_out_valid && out_ready;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin m_rf[r] = '0; m_busy[r] = 1'b0; end
            m_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wb_valid[i] && wb_addr[i*5 +: 5] != 0) begin
                    m_rf[wb_addr[i*5 +: 5]]   = wb_data[i*32 +: 32];
                    m_busy[wb_addr[i*5 +: 5]] = 1'b0;
                end
            end
            if (flush) begin
                m_q.delete();
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (acc) begin
                    e.rs1     = in_rs1_use ? m_rf[in_rs1] : 32'h0;
                    e.rs2     = in_rs2_use ? m_rf[in_rs2] : 32'h0;
                    e.rd      = in_rd;
                    e.rd_we   = in_rd_we;
                    e.payload = in_payload;
                    m_q.push_back(e);
                    if (in_rd_we && in_rd != 0) m_busy[in_rd] = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rs1_use = 1'b0; in_rs2_use = 1'b0; in_rd_we = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        wb_valid = '0; flush = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                         input bit u2, input logic [4:0] rd, input bit we);
        in_valid = 1'b1; in_rs1 = rs1; in_rs1_use = u1; in_rs2 = rs2; in_rs2_use = u2;
        in_rd = rd; in_rd_we = we; in_payload = {$urandom, $urandom};
    endtask

    task automatic wb(input int port, input logic [4:0] addr, input logic [31:0] data);
        wb_valid[port] = 1'b1;
        wb_addr[port*5 +: 5]   = addr;
        wb_data[port*32 +: 32] = data;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); out_ready = 1'b0;
        tick(); tick();
        in_valid = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (got !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", got); end
        tick();
        rst = 1'b0; idle();
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_basic();
        idle(); out_ready = 1'b1;
        wb(0, 5'd5, 32'h1234);
        tick();
        idle(); issue(5'd5, 1, 5'd0, 1, 5'd9, 0);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got=%b exp=0", out_valid); end
        tick();
        idle();
        #1; model_comb();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        n_tests++; if (out_rs1_data !== 32'h1234) begin n_fail++; $display("FAIL basic_rs1 got=%h exp=1234", out_rs1_data); end
        n_tests++; if (out_rs2_data !== 32'h0) begin n_fail++; $display("FAIL basic_rs2 got=%h exp=0", out_rs2_data); end
        n_tests++; if (got !== e_head) begin n_fail++; $display("FAIL basic_entry got=%h exp=%h", got, e_head); end
        tick();
    endtask

    task automatic test_raw_forward();
        idle(); out_ready = 1'b1;
        issue(5'd0, 0, 5'd0, 0, 5'd3, 1);
        tick();
        issue(5'd3, 1, 5'd0, 0, 5'd0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready k=%0d got=%b exp=0", k, in_ready); end
            n_tests++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_flag k=%0d got=%b exp=1", k, hazard_stall); end
            tick();
        end
        wb(1, 5'd3, 32'hAA);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_fwd_ready got=%b exp=1", in_ready); end
        n_tests++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL raw_fwd_flag got=%b exp=0", hazard_stall); end
        tick();
        idle();
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_rs1_data !== 32'hAA) begin
            n_fail++; $display("FAIL raw_fwd_data got=%b/%h exp=1/aa", out_valid, out_rs1_data);
        end
        tick();
    endtask

    task automatic test_waw();
        idle(); out_ready = 1'b1;
        issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
        tick();
        issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
        #1;
        n_tests++; if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL waw_stall got=%b/%b exp=1/0", hazard_stall, in_ready);
        end
        tick();
        wb(0, 5'd7, 32'h77);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_accept got=%b exp=1", in_ready); end
        tick();
        idle(); issue(5'd7, 1, 5'd0, 0, 5'd0, 0);
        #1;
        n_tests++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL waw_set_wins got=%b exp=1", hazard_stall); end
        tick();
        wb(0, 5'd7, 32'h78);
        tick();
        idle(); tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] sent [$];
        int pushed = 0;
        int popped = 0;
        idle(); out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            issue(5'd0, 0, 5'd0, 0, 5'd0, 0);
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill k=%0d got=%b exp=1", k, in_ready); end
            if (in_ready) begin sent.push_back(in_payload); pushed++; end
            tick();
        end
        issue(5'd0, 0, 5'd0, 0, 5'd0, 0);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        tick();
        for (int c = 0; c < 100 && popped < 10; c++) begin
            idle();
            if (pushed < 10) issue(5'd0, 0, 5'd0, 0, 5'd0, 0);
            out_ready = (c % 2) == 0;
            #1; model_comb();
            n_tests++; if (in_ready !== e_in_ready || out_valid !== e_out_valid) begin
                n_fail++; $display("FAIL bp_handshake c=%0d got=%b/%b exp=%b/%b", c, in_ready, out_valid, e_in_ready, e_out_valid);
            end
            if (out_valid && out_ready) begin
                n_tests++; if (sent.size() == 0 || out_payload !== sent[0]) begin
                    n_fail++; $display("FAIL bp_order c=%0d got=%h", c, out_payload);
                end
                if (sent.size() != 0) void'(sent.pop_front());
                popped++;
            end
            if (in_valid && in_ready) begin sent.push_back(in_payload); pushed++; end
            tick();
        end
        n_tests++; if (popped != 10 || sent.size() != 0) begin
            n_fail++; $display("FAIL bp_count popped=%0d left=%0d exp=10/0", popped, sent.size());
        end
        idle();
    endtask

    task automatic test_flush();
        idle(); out_ready = 1'b0;
        issue(5'd0, 0, 5'd0, 0, 5'd4, 1);
        tick();
        issue(5'd0, 0, 5'd0, 0, 5'd0, 0);
        tick();
        idle(); flush = 1'b1; wb(0, 5'd9, 32'h55);
        issue(5'd0, 0, 5'd0, 0, 5'd0, 0);
        #1;
        n_tests++; if (in_ready !== 1'b0 || hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_block got=%b/%b exp=0/0", in_ready, hazard_stall);
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid got=%b exp=1", out_valid); end
        tick();
        idle();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
        issue(5'd4, 1, 5'd9, 1, 5'd4, 1);
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1 || hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy_clear got=%b/%b exp=1/0", in_ready, hazard_stall);
        end
        tick();
        idle();
        #1; model_comb();
        n_tests++; if (out_rs2_data !== 32'h55 || got !== e_head) begin
            n_fail++; $display("FAIL flush_wb_kept got=%h exp=%h", got, e_head);
        end
        wb(0, 5'd4, 32'h44);
        tick();
        idle();
    endtask

    task automatic test_collision();
        idle(); out_ready = 1'b1;
        wb(0, 5'd2, 32'h1); wb(1, 5'd2, 32'h2);
        tick();
        idle(); wb(0, 5'd0, 32'hDEAD);
        tick();
        idle(); issue(5'd2, 1, 5'd0, 1, 5'd0, 0);
        tick();
        idle();
        #1;
        n_tests++; if (out_rs1_data !== 32'h2 || out_rs2_data !== 32'h0) begin
            n_fail++; $display("FAIL collision got=%h/%h exp=2/0", out_rs1_data, out_rs2_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle();
            rst   = (c == 300);
            flush = (c == 0) || ($urandom_range(0, 39) == 0);
            in_valid   = $urandom_range(0, 3) != 0;
            in_rs1     = 5'($urandom_range(0, 7));
            in_rs2     = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 7));
            in_rs1_use = 1'($urandom_range(0, 1));
            in_rs2_use = 1'($urandom_range(0, 1));
            in_rd_we   = 1'($urandom_range(0, 1));
            in_payload = {$urandom, $urandom};
            out_ready  = $urandom_range(0, 3) != 0;
            for (int i = 0; i < 2; i++) begin
                wb_valid[i] = 1'($urandom_range(0, 1));
                wb_addr[i*5 +: 5]   = 5'($urandom_range(0, 7));
                wb_data[i*32 +: 32] = $urandom;
            end
            if (wb_valid == 2'b11 && wb_addr[4:0] == wb_addr[9:5]) wb_valid[1] = 1'b0;
            #1; model_comb();
            n_tests++; if (in_ready !== e_in_ready) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, e_in_ready); end
            n_tests++; if (hazard_stall !== e_hstall) begin n_fail++; $display("FAIL rnd_hazard c=%0d got=%b exp=%b", c, hazard_stall, e_hstall); end
            n_tests++; if (out_valid !== e_out_valid) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, e_out_valid); end
            if (e_out_valid) begin
                n_tests++; if (got !== e_head) begin n_fail++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, got, e_head); end
            end
            tick();
        end
        rst = 1'b0; idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_raw_forward();
        test_waw();
        test_backpressure();
        test_flush();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
